// File: rtl/map_port_arbiter.sv
// Two-port arbiter in front of the single combinational map lookup.
// Port 0 (tracer) has priority; port 1 (overlay) is protected by a starvation counter.
module map_port_arbiter #(
  parameter int BITS     = 2,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [3:0]      req0_row,
  input  logic [3:0]      req0_col,
  output logic            req0_ready,
  output logic            resp0_valid,
  output logic [BITS-1:0] resp0_val,
  input  logic            req1_valid,
  input  logic [3:0]      req1_row,
  input  logic [3:0]      req1_col,
  output logic            req1_ready,
  output logic            resp1_valid,
  output logic [BITS-1:0] resp1_val,
  output logic [3:0]      map_row,
  output logic [3:0]      map_col,
  input  logic [BITS-1:0] map_val
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

  logic [WAIT_W-1:0] starve_cnt;
  logic              force1;
  logic              xfer0;
  logic              xfer1;
  logic              s1_valid;
  logic              s1_port;

  // Handshake: a request transfers on a cycle where valid && ready are both high.
  // Ready never depends on the same port's valid, and the two grants are exclusive:
  // req0_ready is low whenever force1 makes req1_ready high, and otherwise
  // req1_ready is high only when req0_valid is low.
  assign force1     = req1_valid && (starve_cnt >= WAIT_LIMIT);
  assign req0_ready = !force1;
  assign req1_ready = !req0_valid || force1;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;

  // Stage 1: register the granted address and tag it with the owning port.
  always_ff @(posedge clk) begin
    if (reset) begin
      map_row  <= '0;
      map_col  <= '0;
      s1_valid <= 1'b0;
      s1_port  <= 1'b0;
    end else begin
      s1_valid <= xfer0 || xfer1;
      if (xfer1) begin
        map_row <= req1_row;
        map_col <= req1_col;
        s1_port <= 1'b1;
      end else if (xfer0) begin
        map_row <= req0_row;
        map_col <= req0_col;
        s1_port <= 1'b0;
      end
    end
  end

  // Stage 2: capture the lookup result into the owning port; the other port's value holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_val   <= '0;
      resp1_val   <= '0;
    end else begin
      resp0_valid <= s1_valid && !s1_port;
      resp1_valid <= s1_valid && s1_port;
      if (s1_valid && !s1_port) resp0_val <= map_val;
      if (s1_valid && s1_port)  resp1_val <= map_val;
    end
  end

  // Counts consecutive cycles port 1 waited; any gap in its request restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!req1_valid || xfer1) begin
      starve_cnt <= '0;
    end else if (starve_cnt != WAIT_SAT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed bench for map_port_arbiter with a fixed dummy map behind the lookup port.
module tb_map_port_arbiter;

  localparam int BITS = 2;

  logic            clk;
  logic            reset;
  logic            req0_valid;
  logic [3:0]      req0_row;
  logic [3:0]      req0_col;
  logic            req0_ready;
  logic            resp0_valid;
  logic [BITS-1:0] resp0_val;
  logic            req1_valid;
  logic [3:0]      req1_row;
  logic [3:0]      req1_col;
  logic            req1_ready;
  logic            resp1_valid;
  logic [BITS-1:0] resp1_val;
  logic [3:0]      map_row;
  logic [3:0]      map_col;
  logic [BITS-1:0] map_val;

  int checks   = 0;
  int failures = 0;
  int p0col;
  logic [BITS-1:0] exp_q[$];
  logic [BITS-1:0] exp_v;

  map_port_arbiter #(.BITS(BITS), .MAX_WAIT(4), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_row(req0_row), .req0_col(req0_col),
    .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_val(resp0_val),
    .req1_valid(req1_valid), .req1_row(req1_row), .req1_col(req1_col),
    .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_val(resp1_val),
    .map_row(map_row), .map_col(map_col), .map_val(map_val)
  );

  // Dummy map contents: diagonal is empty, rows 0 and 15 are walls, else a row/col xor.
  function automatic logic [BITS-1:0] map_model(input logic [3:0] r, input logic [3:0] c);
    if (r == c) return 2'b00;
    if (r == 4'hF || r == 4'h0) return 2'b11;
    return r[1:0] ^ c[1:0];
  endfunction

  assign map_val = map_model(map_row, map_col);

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Contention: accept cycle -> owning port, and hand-computed cell values in issue order
  int exp_port[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_val[10]  = '{1, 0, 3, 2, 2, 1, 0, 3, 2, 2};
  int r1v[9]       = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
  int r1rdy[9]     = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_row = 4'd0; req0_col = 4'd5;
    req1_valid = 1'b0; req1_row = 4'd0; req1_col = 4'd0;

    // Reset held two cycles with a live port-0 request
    tick();
    tick();
    chk("rst_map_row", int'(map_row), 0);
    chk("rst_map_col", int'(map_col), 0);
    chk("rst_resp0_valid", int'(resp0_valid), 0);
    chk("rst_resp1_valid", int'(resp1_valid), 0);
    chk("rst_resp0_val", int'(resp0_val), 0);
    chk("rst_resp1_val", int'(resp1_val), 0);

    // First request after release: row 0 col 5 -> 2'b11 two cycles later
    reset = 1'b0;
    #1;
    chk("first_req0_ready", int'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    chk("first_map_row", int'(map_row), 0);
    chk("first_map_col", int'(map_col), 5);
    chk("first_t1_resp0_valid", int'(resp0_valid), 0);
    tick();
    chk("first_t2_resp0_valid", int'(resp0_valid), 1);
    chk("first_t2_resp0_val", int'(resp0_val), 3);
    chk("first_t2_resp1_valid", int'(resp1_valid), 0);
    tick();
    chk("first_t3_resp0_valid", int'(resp0_valid), 0);

    // Port 1 alone: row 1 col 1 -> 2'b00; port-0 value holds
    req1_valid = 1'b1; req1_row = 4'd1; req1_col = 4'd1;
    #1;
    chk("p1_alone_ready", int'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("p1_alone_resp1_valid", int'(resp1_valid), 1);
    chk("p1_alone_resp1_val", int'(resp1_val), 0);
    chk("p1_alone_resp0_valid", int'(resp0_valid), 0);
    chk("p1_alone_resp0_hold", int'(resp0_val), 3);
    tick();
    chk("p1_alone_resp1_end", int'(resp1_valid), 0);

    // Streaming: row 15, cols 0..3, four back-to-back responses of 2'b11
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        req0_valid = 1'b1; req0_row = 4'd15; req0_col = 4'(i);
        exp_q.push_back(2'b11);
      end else begin
        req0_valid = 1'b0;
      end
      #1;
      if (i < 4) chk("stream_ready", int'(req0_ready), 1);
      if (i >= 2) begin
        exp_v = exp_q.pop_front();
        chk("stream_resp0_valid", int'(resp0_valid), 1);
        chk("stream_resp0_val", int'(resp0_val), int'(exp_v));
      end
      tick();
    end
    chk("stream_end_resp0_valid", int'(resp0_valid), 0);

    // Contention: port 0 wins 4 cycles, port 1 forced on the 5th, twice
    p0col = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        req0_valid = 1'b1; req0_row = 4'd5; req0_col = 4'(p0col);
        req1_valid = 1'b1; req1_row = 4'd3; req1_col = 4'd1;
        exp_q.push_back(BITS'(exp_val[i]));
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (i < 10) begin
        chk("cont_req1_ready", int'(req1_ready), exp_port[i]);
        chk("cont_req0_ready", int'(req0_ready), 1 - exp_port[i]);
      end
      if (i >= 2) begin
        exp_v = exp_q.pop_front();
        if (exp_port[i-2] == 1) begin
          chk("cont_resp1_valid", int'(resp1_valid), 1);
          chk("cont_resp1_val", int'(resp1_val), int'(exp_v));
          chk("cont_resp0_quiet", int'(resp0_valid), 0);
        end else begin
          chk("cont_resp0_valid", int'(resp0_valid), 1);
          chk("cont_resp0_val", int'(resp0_val), int'(exp_v));
          chk("cont_resp1_quiet", int'(resp1_valid), 0);
        end
      end
      tick();
      if (i < 10 && exp_port[i] == 0) p0col++;
    end
    chk("cont_end_resp0_valid", int'(resp0_valid), 0);
    chk("cont_end_resp1_valid", int'(resp1_valid), 0);

    // Counter clear: 3 denied, 1 idle, then 4 more denied before the forced grant
    for (int i = 0; i < 9; i++) begin
      req0_valid = 1'b1; req0_row = 4'd15; req0_col = 4'd0;
      req1_valid = r1v[i][0]; req1_row = 4'd2; req1_col = 4'd0;
      #1;
      chk("clr_req1_ready", int'(req1_ready), r1rdy[i]);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("clr_drain_resp0", int'(resp0_valid), 0);
    chk("clr_drain_resp1", int'(resp1_valid), 0);

    // Reset mid-flight: lookup accepted, then reset discards it
    req0_valid = 1'b1; req0_row = 4'd2; req0_col = 4'd1;
    #1;
    chk("mid_req0_ready", int'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    chk("mid_map_row_pre", int'(map_row), 2);
    chk("mid_map_col_pre", int'(map_col), 1);
    tick();
    reset = 1'b0;
    chk("mid_resp0_valid", int'(resp0_valid), 0);
    chk("mid_map_row", int'(map_row), 0);
    chk("mid_map_col", int'(map_col), 0);
    tick();
    chk("mid_after_resp0_valid", int'(resp0_valid), 0);
    chk("mid_after_resp1_valid", int'(resp1_valid), 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/map_port_arbiter.md
Name: map_port_arbiter

Overview:
Shares the single combinational map lookup port (4-bit row, 4-bit col, BITS-wide cell value) between two requesters. Port 0 is the ray tracer (priority); port 1 is the map-overlay/debug renderer. The block registers the lookup address and the returned cell, giving a fixed 2-cycle pipelined read with one accept per cycle. An anti-starvation counter forces a port-1 grant after MAX_WAIT consecutive denied cycles.

Parameters:
BITS, 2, width of one map cell value
MAX_WAIT, 4, consecutive denied cycles of port 1 before a forced grant; range 1..15
WAIT_W, 4, width of the starvation counter; must hold MAX_WAIT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  tracer lookup request
req0_row  in  4  tracer map row
req0_col  in  4  tracer map col
req0_ready  out  1  grant to port 0; transfer when valid&ready
resp0_valid  out  1  port-0 read data valid, one-cycle pulse
resp0_val  out  BITS  port-0 cell value
req1_valid  in  1  overlay lookup request
req1_row  in  4  overlay map row
req1_col  in  4  overlay map col
req1_ready  out  1  grant to port 1
resp1_valid  out  1  port-1 read data valid, one-cycle pulse
resp1_val  out  BITS  port-1 cell value
map_row  out  4  registered row to map lookup
map_col  out  4  registered col to map lookup
map_val  in  BITS  combinational cell value from map lookup

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: map_row=0, map_col=0, resp0_valid=0, resp1_valid=0, resp0_val=0, resp1_val=0, starvation counter=0, pipeline tags cleared.
- force1 = req1_valid && (starve_cnt >= MAX_WAIT).
- Ready (combinational, independent of own valid): req0_ready = !force1; req1_ready = !req0_valid || force1. Exactly one port transfers per cycle at most.
- Accept (cycle t, edge at end of t): map_row/map_col <= granted port's row/col; stage-1 tag <= {valid, port id}. With no transfer, map_row/map_col hold and the stage-1 valid is cleared.
- Stage 2 (edge at end of t+1): the selected respN_val <= map_val; respN_valid <= 1 for cycle t+2 only. The other port's resp_valid is 0, and its resp_val holds its last value.
- Latency: request accepted in cycle t -> response valid in cycle t+2. Throughput: 1 accept per cycle. Back-to-back and interleaved accepts return in issue order.
- No response back-pressure: requesters must sample respN_val when respN_valid is high.
- Starvation counter:
  - Increments (saturating at 2^WAIT_W-1) on each cycle with req1_valid && !req1_ready.
  - Clears to 0 on a port-1 transfer or any cycle with req1_valid low.
- Both valid, counter < MAX_WAIT: port 0 wins.
- Both valid, counter >= MAX_WAIT: port 1 wins; the counter clears the next cycle.
- Single requester: granted immediately, every cycle.
- Requesters must hold row/col stable while valid && !ready.
- Reset mid-operation: in-flight lookups are discarded; no resp_valid is asserted in the cycle after reset deasserts.
- The block has no state machine beyond the 2-stage valid/tag pipeline and the counter.

Test Plan:
- Reset: hold reset 2 cycles with req0_valid=1 -> all outputs 0, no resp pulses. After release, req0 (row 0, col 5) accepted in cycle t -> resp0_valid=1, resp0_val=2'b11 in cycle t+2 (bench uses dummy map lookup model).
- Port-1 alone: req1 (row 1, col 1) -> req1_ready=1 the same cycle, resp1_val=2'b00 two cycles later; resp0_valid stays 0.
- Streaming: req0_valid held 4 cycles with cols 0..3 on row 15 -> four consecutive resp0_valid pulses, each value 2'b11, in order, starting at t+2.
- Contention/starvation, MAX_WAIT=4, both valid continuously:
  - Port 0 is granted for 4 cycles, then req1_ready=1 on the 5th cycle.
  - The counter clears, and the 4-then-1 pattern repeats.
  - Responses alternate per issue order.
- Counter clear: req1_valid high 3 denied cycles, low 1 cycle, high again with req0 busy -> 4 more denied cycles before the forced grant.
- Reset mid-flight: accept req0 in cycle t, assert reset in t+1 -> no resp0_valid in t+2; map_row/map_col=0 after reset.
